// File: rtl/tx_frame_shifter.sv
// UART transmit framer: one-entry holding buffer feeding a start/data/parity/stop
// shift register that advances one bit per bit_tick, LSB first.
module tx_frame_shifter #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_tick,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            in_parity_mode,
  input  logic                  in_two_stop,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int FRAME_W = DATA_WIDTH + 4;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] buf_data;
  logic [1:0]            buf_mode;
  logic                  buf_two;
  logic [FRAME_W-1:0]    shreg;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  accept;
  logic                  frame_end;
  logic                  load;

  // Bits above the last used position are ones, so they double as stop bits.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [DATA_WIDTH-1:0] d,
                                                     input logic [1:0]            m);
    logic [FRAME_W-1:0] f;
    f               = '1;
    f[0]            = 1'b0;
    f[DATA_WIDTH:1] = d;
    if (m == 2'b01)      f[DATA_WIDTH+1] = ^d;
    else if (m == 2'b10) f[DATA_WIDTH+1] = ~^d;
    return f;
  endfunction

  // Index of the final stop bit, i.e. frame length minus one.
  function automatic logic [CNT_WIDTH-1:0] last_index(input logic [1:0] m,
                                                      input logic       two);
    logic [CNT_WIDTH-1:0] n;
    n = CNT_WIDTH'(DATA_WIDTH + 1);
    if (m == 2'b01 || m == 2'b10) n = n + CNT_WIDTH'(1);
    if (two)                      n = n + CNT_WIDTH'(1);
    return n;
  endfunction

  always_comb begin
    accept    = in_valid && in_ready;
    frame_end = (state == SHIFT) && bit_tick && (cnt == '0);
    load      = bit_tick && !in_ready && ((state == IDLE) || (cnt == '0));
  end

  assign tx = shreg[0];

  always_ff @(posedge clk) begin
    if (accept) begin
      buf_data <= in_data;
      buf_mode <= in_parity_mode;
      buf_two  <= in_two_stop;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      shreg    <= '1;
      cnt      <= '0;
    end else begin
      done <= frame_end;
      if (accept) in_ready <= 1'b0;
      if (load) begin
        shreg    <= build_frame(buf_data, buf_mode);
        cnt      <= last_index(buf_mode, buf_two);
        busy     <= 1'b1;
        in_ready <= 1'b1;
        state    <= SHIFT;
      end else if (frame_end) begin
        shreg <= '1;
        busy  <= 1'b0;
        state <= IDLE;
      end else if (state == SHIFT && bit_tick) begin
        shreg <= {1'b1, shreg[FRAME_W-1:1]};
        cnt   <= cnt - CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_tx_frame_shifter.sv
// Bench for tx_frame_shifter: per-tick scoreboard on an 8-bit instance plus a
// directed frame on a 5-bit instance.
module tb_tx_frame_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_tick;
  logic [7:0] in_data;
  logic [1:0] in_parity_mode;
  logic       in_two_stop;
  logic       in_valid;
  logic       in_ready, tx, busy, done;

  logic [4:0] d5_data;
  logic       d5_valid;
  logic       d5_ready, tx5, busy5, done5;

  int checks = 0;
  int failures = 0;
  int tick_period = 16;
  int tcnt = 0;
  int tick_seen = 0;
  logic prev_tx = 1'b1;

  typedef struct {
    logic tx;
    logic busy;
    logic done;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  mode;
    logic        two;
    int          n;
    logic [12:0] bits;
    int          period;
  } vec_t;
  vec_t vecs[6];

  tx_frame_shifter #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .bit_tick(bit_tick), .in_data(in_data),
    .in_parity_mode(in_parity_mode), .in_two_stop(in_two_stop),
    .in_valid(in_valid), .in_ready(in_ready), .tx(tx), .busy(busy), .done(done)
  );

  tx_frame_shifter #(.DATA_WIDTH(5), .CNT_WIDTH(4)) dut5 (
    .clk(clk), .rst(rst), .bit_tick(bit_tick), .in_data(d5_data),
    .in_parity_mode(2'b10), .in_two_stop(1'b0),
    .in_valid(d5_valid), .in_ready(d5_ready), .tx(tx5), .busy(busy5), .done(done5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-tick line state; a frame accepted while another is in
  // flight starts on the previous frame's done tick.
  task automatic push_frame(input logic [12:0] bits, input int n);
    if (q.size() > 0) q[q.size()-1] = '{tx: bits[0], busy: 1'b1, done: 1'b1};
    else              q.push_back('{tx: bits[0], busy: 1'b1, done: 1'b0});
    for (int i = 1; i < n; i++) q.push_back('{tx: bits[i], busy: 1'b1, done: 1'b0});
    q.push_back('{tx: 1'b1, busy: 1'b0, done: 1'b1});
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] m, input logic two,
                      input logic [12:0] bits, input int n);
    @(negedge clk);
    in_data = d; in_parity_mode = m; in_two_stop = two; in_valid = 1'b1;
    for (int i = 0; i < 4000 && !in_ready; i++) @(negedge clk);
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #2;
      push_frame(bits, n);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_ticks(input int k);
    int snap;
    snap = tick_seen;
    for (int i = 0; i < k * 64 + 64 && tick_seen < snap + k; i++) begin
      @(posedge clk);
      #2;
    end
    if (tick_seen < snap + k) chk("tick_timeout", tick_seen, snap + k);
  endtask

  task automatic drain();
    for (int i = 0; i < 20000 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    wait_ticks(2);
  endtask

  initial begin
    bit_tick = 1'b0;
    forever begin
      @(negedge clk);
      tcnt++;
      if (tcnt >= tick_period) begin
        bit_tick = 1'b1;
        tcnt = 0;
      end else begin
        bit_tick = 1'b0;
      end
    end
  end

  // Line monitor: every tick is compared against the scoreboard (idle line
  // when empty); between ticks tx must hold and done must stay low.
  initial begin
    exp_t e;
    logic tk, r0;
    forever begin
      @(posedge clk);
      tk = bit_tick;
      r0 = rst;
      #1;
      if (!r0 || !rst) begin
        prev_tx = 1'b1;
      end else if (tk) begin
        if (q.size() > 0) e = q.pop_front();
        else              e = '{tx: 1'b1, busy: 1'b0, done: 1'b0};
        chk("tick_tx", tx, e.tx);
        chk("tick_busy", busy, e.busy);
        chk("tick_done", done, e.done);
        tick_seen++;
        prev_tx = tx;
      end else begin
        chk("hold_done", done, 0);
        chk("hold_tx", tx, prev_tx);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bits5;
    int snap;
    vecs[0] = '{data: 8'hA5, mode: 2'b00, two: 1'b0, n: 10, bits: 13'b1_10100101_0,    period: 16};
    vecs[1] = '{data: 8'hA5, mode: 2'b01, two: 1'b1, n: 12, bits: 13'b11_0_10100101_0, period: 16};
    vecs[2] = '{data: 8'hA5, mode: 2'b10, two: 1'b0, n: 11, bits: 13'b1_1_10100101_0,  period: 16};
    vecs[3] = '{data: 8'h3C, mode: 2'b11, two: 1'b1, n: 11, bits: 13'b11_00111100_0,   period: 1};
    vecs[4] = '{data: 8'h07, mode: 2'b01, two: 1'b1, n: 12, bits: 13'b11_1_00000111_0, period: 3};
    vecs[5] = '{data: 8'h01, mode: 2'b10, two: 1'b0, n: 11, bits: 13'b1_0_00000001_0,  period: 16};

    rst = 1'b0;
    in_data = '0; in_parity_mode = '0; in_two_stop = 1'b0; in_valid = 1'b0;
    d5_data = '0; d5_valid = 1'b0;
    #12;
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ready", in_ready, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Single frames from an idle line, several formats and tick spacings.
    for (int v = 0; v < 6; v++) begin
      tick_period = vecs[v].period;
      send(vecs[v].data, vecs[v].mode, vecs[v].two, vecs[v].bits, vecs[v].n);
      if (v == 0) begin
        wait_ticks(1);
        chk("ready_after_load", in_ready, 1);
      end
      drain();
    end
    tick_period = 16;

    // Back-to-back words: second start bit directly after first stop bit.
    send(8'h00, 2'b00, 1'b0, 13'b1_00000000_0, 10);
    send(8'hFF, 2'b00, 1'b0, 13'b1_11111111_0, 10);
    drain();

    // Config churn while a frame is in flight and another waits in the buffer.
    send(8'hA5, 2'b01, 1'b1, 13'b11_0_10100101_0, 12);
    send(8'h01, 2'b10, 1'b0, 13'b1_0_00000001_0, 11);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      in_parity_mode = 2'($urandom);
      in_two_stop    = 1'($urandom);
      in_data        = 8'($urandom);
    end
    in_parity_mode = 2'b00; in_two_stop = 1'b0;
    drain();

    // Asynchronous reset in the middle of data bit 4.
    send(8'hA5, 2'b00, 1'b0, 13'b1_10100101_0, 10);
    wait_ticks(5);
    @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("midreset_tx", tx, 1);
    chk("midreset_busy", busy, 0);
    chk("midreset_ready", in_ready, 1);
    chk("midreset_done", done, 0);
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_ticks(4);

    // 5-bit instance, 0x15 odd parity one stop bit.
    bits5 = 8'b1_0_10101_0;
    @(negedge clk);
    d5_data = 5'h15; d5_valid = 1'b1;
    for (int i = 0; i < 100 && !d5_ready; i++) @(negedge clk);
    @(negedge clk);
    d5_valid = 1'b0;
    for (int b = 0; b < 9; b++) begin
      snap = 0;
      for (int i = 0; i < 64 && snap == 0; i++) begin
        @(posedge clk);
        if (bit_tick) snap = 1;
      end
      #1;
      if (snap == 0) chk("w5_tick_timeout", snap, 1);
      if (b < 8) begin
        chk("w5_tx", tx5, bits5[b]);
        chk("w5_busy", busy5, 1);
      end else begin
        chk("w5_done", done5, 1);
        chk("w5_idle_tx", tx5, 1);
        chk("w5_idle_busy", busy5, 0);
      end
    end

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_frame_shifter.md
Name: tx_frame_shifter

Overview:
Parametrised UART transmit framer and serialiser. It accepts parallel words over a valid/ready handshake into a one-entry holding buffer. Each word is framed with start, optional parity and one or two stop bits, then shifted out LSB-first on `tx`, one bit per `bit_tick`. It sits between the TX data source and the pin, and is paced by the baud generator's per-bit tick.

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- CNT_WIDTH, 4, bit-counter width; must hold DATA_WIDTH+4.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- bit_tick  in  1  one-cycle pulse per bit period from the baud generator.
- in_data  in  DATA_WIDTH  word to transmit.
- in_parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- in_two_stop  in  1  0: one stop bit; 1: two stop bits.
- in_valid  in  1  source has a word.
- in_ready  out  1  holding buffer empty; registered.
- tx  out  1  serial line; idle high.
- busy  out  1  frame in progress on tx.
- done  out  1  one-cycle pulse when a frame's last stop bit completes.

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-frame):
  - tx=1, busy=0, done=0, in_ready=1.
  - Holding buffer is emptied and any partial frame is discarded. No resumption after reset.
- Accept:
  - A transfer occurs on an edge where in_valid=1 and in_ready=1.
  - in_data, in_parity_mode and in_two_stop are captured together into the holding buffer.
  - in_ready=0 from the next cycle until the buffer transfers to the shifter.
  - in_ready is a pure register output (no combinational path from in_valid).
- Frame format, LSB-first:
  - Start bit (0), then data[0]..data[DATA_WIDTH-1].
  - Parity bit if the mode is even or odd. Even: XOR of data bits. Odd: inverted XOR.
  - Then 1 or 2 stop bits (1).
  - Frame length N = 1 + DATA_WIDTH + P + S, with P∈{0,1} and S∈{1,2}.
- State machine:
  - IDLE: tx=1, busy=0. On an edge with bit_tick=1 and the buffer full:
    - Load the buffer into the shifter.
    - Drive tx=0 (start bit) and set busy=1.
    - Empty the buffer, so in_ready=1 next cycle.
    - Go to SHIFT.
  - SHIFT: each edge with bit_tick=1 advances to the next frame bit. Between ticks, tx is held.
  - Frame end: on the tick that would follow the final stop bit:
    - done=1 for that cycle only.
    - If the buffer is full, load the next frame on that same edge (tx=0, busy stays 1, back-to-back with no idle bit).
    - Otherwise go to IDLE: tx=1, busy=0.
- Each bit is held for exactly one tick period. The start bit begins at load tick T, and done fires at tick T+N.
- Configuration is sampled per word at accept time. Changing the mode inputs mid-frame has no effect on the frame in flight.
- bit_tick pulses with the buffer empty in IDLE: no effect. bit_tick held high for consecutive cycles: each cycle counts as a tick.
- Accepting a word while SHIFT is active is legal and does not disturb tx.
- The bit counter wraps only through the load/reset path, never by overflow.

Test Plan:
- Reset, then 0xA5 with mode 00 and one stop bit, ticks every 16 cycles → tx per tick = 0,1,0,1,0,0,1,0,1,1; done at tick 10; busy deasserts on the same edge; in_ready=1 from the cycle after load.
- 0xA5 with mode even, two stop bits → tx = 0,1,0,1,0,0,1,0,1,0(parity),1,1; N=12. The same word with mode odd gives parity 1.
- Two words pushed back-to-back (0x00 then 0xFF, 8N1) → the second is accepted while the first shifts; the second start bit follows the first stop bit directly; 20 ticks total; two done pulses 10 ticks apart.
- DATA_WIDTH=5, word 0x15, mode odd, one stop → tx = 0,1,0,1,0,1,0(parity),1; N=8.
- rst=0 asserted asynchronously at bit 4 of a frame → tx=1, busy=0, in_ready=1 immediately; after release, the line stays idle with no residual bits or done pulse.
- Mode inputs toggled and in_valid held high mid-frame → the in-flight frame is unchanged; the new word is captured once, with its own sampled configuration.
